ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
- Parametrised, clocked successor of the datapath ALU. Operates on WIDTH-bit signed operands from the accumulator (ac) and memory buffer register (mbr).
- Single-cycle logic/add/sub ops; multi-cycle iterative multiply and divide.
- Start/busy/done handshake, registered result and flags, tri-stated result bus.
- Sits between AC/MBR and the shared internal bus, sequenced by the control unit.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).
- SEL_W, 4, opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- ac  input  WIDTH  signed operand A.
- mbr  input  WIDTH  signed operand B.
- ula_sel  input  SEL_W  opcode, sampled on start.
- start  input  1  request; accepted only when busy=0.
- ula_re  input  1  result bus output enable.
- result  output  WIDTH  registered result when ula_re=1, else all-Z.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when result/flags update.
- flagz  output  1  registered result == 0.
- flagn  output  1  registered result < 0.
- flagdz  output  1  last divide had mbr == 0.

Behaviour:
- Reset:
  - Synchronous; only clk and rst are decided.
  - Result register 0; busy, done, flagz, flagn, flagdz all 0; FSM to IDLE.
  - rst during MUL/DIV aborts the operation; no done pulse.
- Opcodes: 0010 add, 0011 sub, 0100 mul, 0101 div, 0110 and, 0111 or, 1000 not (~ac). All others are invalid.
- Operand/opcode capture: ac, mbr and ula_sel are registered at accept. Later input changes do not affect the operation in flight.
- FSM states: IDLE, EXEC, MUL, DIV, FIN.
  - IDLE + start: go to EXEC (add/sub/and/or/not/invalid), MUL, or DIV.
  - EXEC: done=1 next cycle. Latency 1: accept at cycle T, done and new result at T+1.
  - MUL: shift-add on operand magnitudes, one bit per cycle, WIDTH iterations, then sign correction. done at T+WIDTH+1.
  - DIV: restoring division on magnitudes, WIDTH iterations, sign correction. done at T+WIDTH+1.
  - busy=1 from T+1 until the cycle done is high, inclusive. For EXEC, busy and done are both high at T+1.
  - start in a done cycle is ignored. start while busy is ignored; nothing is queued.
- Arithmetic:
  - add/sub/mul wrap modulo 2^WIDTH; mul keeps the low WIDTH bits of the signed product.
  - div truncates toward zero; remainder is discarded.
  - Most-negative / -1 wraps to most-negative.
- Divide by zero: result 0, flagz=1, flagn=0, flagdz=1. Latency is unchanged (full WIDTH+1).
- flagdz is cleared by any other completed op.
- Flags: flagz and flagn update in the same cycle as the result register, and only at done.
- Invalid opcode: done pulses at T+1; result and all flags are held.
- result port: combinational mux of the result register and Z on ula_re. ula_re has no effect on internal state; busy/done operate regardless of ula_re.

Optional Feature:
- Macro: ULA_OVF_EN.
- Defined: extra output port flagv (1 bit, reset 0), updated at done.
  - add/sub: set on signed overflow.
  - mul: set when the true product does not fit in WIDTH signed bits.
  - div: set for most-negative / -1.
  - Cleared for and/or/not and divide by zero.
  - Held on invalid opcode.
- Undefined: no flagv port, no overflow logic.

Test Plan:
- WIDTH=16. add, ac=5, mbr=-7, start at T -> at T+1: done=1, result=0xFFFE (-2), flagn=1, flagz=0. With ula_re=0 -> result=Z.
- sub, ac=3, mbr=3 -> T+1: result=0, flagz=1. Then and 0x00F0 & 0x0F0F -> result=0x0000, flagz=1. Then or -> 0x0FFF.
- mul, ac=-3, mbr=7 -> busy T+1..T+17; done only at T+17; result=-21 (0xFFEB), flagn=1.
- Second start at T+5 during that mul -> ignored: result=-21, one done pulse total.
- div, ac=-7, mbr=2 -> T+17: result=-3.
- div, 0x8000 / -1 -> result=0x8000. With ULA_OVF_EN: flagv=1.
- div, ac=9, mbr=0 -> T+17: result=0, flagdz=1, flagz=1. Next add 1+1 -> flagdz=0, result=2.
- Start mul, assert rst at T+6 for one cycle -> next cycle busy=0, result=0, flags=0, no done. New add accepted immediately after with latency 1.

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq: clocked ALU with single-cycle add/sub/logic ops and iterative shift-add multiply / restoring divide.
// Define ULA_OVF_EN to add the registered signed-overflow flag output flagv.
module ula_seq #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ac,
    input  logic [WIDTH-1:0] mbr,
    input  logic [SEL_W-1:0] ula_sel,
    input  logic             start,
    input  logic             ula_re,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             flagz,
    output logic             flagn,
    output logic             flagdz
`ifdef ULA_OVF_EN
    ,
    output logic             flagv
`endif
);

    localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(2);
    localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(4);
    localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(5);
    localparam logic [SEL_W-1:0] OP_AND = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(7);
    localparam logic [SEL_W-1:0] OP_NOT = SEL_W'(8);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   neg_q, neg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       dvsr_q, dvsr_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   flagz_q, flagz_d;
    logic                   flagn_q, flagn_d;
    logic                   flagdz_q, flagdz_d;

    logic [WIDTH-1:0]       mag_ac;
    logic [WIDTH-1:0]       mag_mbr;
    logic [WIDTH-1:0]       sum;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_trial;
    logic                   commit;
    logic                   dz_new;
    logic [WIDTH-1:0]       res_new;

    assign mag_ac  = ac[WIDTH-1]  ? -ac  : ac;
    assign mag_mbr = mbr[WIDTH-1] ? -mbr : mbr;
    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        commit    = 1'b0;
        dz_new    = 1'b0;
        res_new   = '0;
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, dvsr_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d = ula_sel;
                    a_d   = ac;
                    b_d   = mbr;
                    neg_d = ac[WIDTH-1] ^ mbr[WIDTH-1];
                    cnt_d = '0;
                    case (ula_sel)
                        OP_MUL: begin
                            state_d  = MUL;
                            prod_d   = '0;
                            mcand_d  = {{WIDTH{1'b0}}, mag_ac};
                            mplier_d = mag_mbr;
                        end
                        OP_DIV: begin
                            state_d = DIV;
                            rem_d   = '0;
                            quo_d   = mag_ac;
                            dvsr_d  = mag_mbr;
                        end
                        default: state_d = EXEC;
                    endcase
                end
            end

            // Invalid opcodes still finish through FIN so done pulses, but nothing is committed.
            EXEC: begin
                state_d = FIN;
                commit  = 1'b1;
                case (sel_q)
                    OP_ADD:  res_new = sum;
                    OP_SUB:  res_new = diff;
                    OP_AND:  res_new = a_q & b_q;
                    OP_OR:   res_new = a_q | b_q;
                    OP_NOT:  res_new = ~a_q;
                    default: commit  = 1'b0;
                endcase
            end

            MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                    commit  = 1'b1;
                    res_new = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end

            // A zero divisor still runs all iterations so latency never depends on the data.
            DIV: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                    commit  = 1'b1;
                    if (dvsr_q == '0) begin
                        dz_new = 1'b1;
                    end else begin
                        res_new = neg_q ? -quo_q : quo_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!div_trial[WIDTH]) begin
                        rem_d = div_trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end

            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_d = result_q;
        flagz_d  = flagz_q;
        flagn_d  = flagn_q;
        flagdz_d = flagdz_q;
        if (commit) begin
            result_d = res_new;
            flagz_d  = (res_new == '0);
            flagn_d  = res_new[WIDTH-1];
            flagdz_d = dz_new;
        end
        // busy covers the cycles after acceptance up to and including the done cycle.
        busy_d = (state_q != IDLE) && (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flagz_q  <= 1'b0;
            flagn_q  <= 1'b0;
            flagdz_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            flagz_q  <= flagz_d;
            flagn_q  <= flagn_d;
            flagdz_q <= flagdz_d;
        end
    end

`ifdef ULA_OVF_EN
    localparam logic [2*WIDTH-1:0] MAG_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] MAG_MIN = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    logic flagv_q, flagv_d;
    logic ovf_new;

    // Overflow is judged on the operation completing this cycle; it is only used when commit is high.
    always_comb begin
        ovf_new = 1'b0;
        case (state_q)
            EXEC: begin
                case (sel_q)
                    OP_ADD:  ovf_new = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
                    OP_SUB:  ovf_new = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
                    default: ovf_new = 1'b0;
                endcase
            end
            MUL:     ovf_new = neg_q ? (prod_q > MAG_MIN) : (prod_q > MAG_MAX);
            DIV:     ovf_new = (dvsr_q != '0) && !neg_q && quo_q[WIDTH-1];
            default: ovf_new = 1'b0;
        endcase
        flagv_d = commit ? ovf_new : flagv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flagv_q <= 1'b0;
        end else begin
            flagv_q <= flagv_d;
        end
    end

    assign flagv = flagv_q;
`endif

    assign result = ula_re ? result_q : {WIDTH{1'bz}};
    assign busy   = busy_q;
    assign done   = done_q;
    assign flagz  = flagz_q;
    assign flagn  = flagn_q;
    assign flagdz = flagdz_q;

endmodule

// File: tb/tb_ula_seq.sv
// Testbench for ula_seq: directed scenarios plus randomized operations checked against an arithmetic reference model.
// Build with ULA_OVF_EN defined to also check flagv.
module tb_ula_seq;

    localparam int WIDTH   = 16;
    localparam int SEL_W   = 4;
    localparam int MUL_LAT = WIDTH + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     ac;
    logic [WIDTH-1:0]     mbr;
    logic [SEL_W-1:0]     ula_sel;
    logic                 start;
    logic                 ula_re;
    tri1  [WIDTH-1:0]     resultBus;
    logic                 busy;
    logic                 done;
    logic                 flagz;
    logic                 flagn;
    logic                 flagdz;
`ifdef ULA_OVF_EN
    logic                 flagv;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: what the result register and flags should hold right now.
    logic [WIDTH-1:0] mRes;
    bit               mZ, mN, mDz, mV;

    ula_seq #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ac      (ac),
        .mbr     (mbr),
        .ula_sel (ula_sel),
        .start   (start),
        .ula_re  (ula_re),
        .result  (resultBus),
        .busy    (busy),
        .done    (done),
        .flagz   (flagz),
        .flagn   (flagn),
        .flagdz  (flagdz)
`ifdef ULA_OVF_EN
        ,
        .flagv   (flagv)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Behavioural model: plain signed integer arithmetic on 64-bit values, then truncate.
    task automatic refModel(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            output bit valid, output logic [WIDTH-1:0] res, output bit ovf,
                            output bit dz, output int lat);
        longint sa, sb, full;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        full  = 0;
        valid = 1;
        ovf   = 0;
        dz    = 0;
        lat   = (op == 4'd4 || op == 4'd5) ? MUL_LAT : 1;
        case (op)
            4'd2: full = sa + sb;
            4'd3: full = sa - sb;
            4'd4: full = sa * sb;
            4'd5: begin
                if (sb == 0) dz = 1;
                else         full = sa / sb;
            end
            4'd6: full = longint'(a & b);
            4'd7: full = longint'(a | b);
            4'd8: full = longint'(~a);
            default: valid = 0;
        endcase
        if (op >= 4'd2 && op <= 4'd5) begin
            ovf = (full > 32767) || (full < -32768);
        end
        res = WIDTH'(full);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_result"}, resultBus, mRes);
        checkOutput({tag, "_flagz"}, flagz, mZ);
        checkOutput({tag, "_flagn"}, flagn, mN);
        checkOutput({tag, "_flagdz"}, flagdz, mDz);
`ifdef ULA_OVF_EN
        checkOutput({tag, "_flagv"}, flagv, mV);
`endif
    endtask

    // Issue one operation from idle, optionally poke start again after observing cycle reStartAfter.
    task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int reStartAfter);
        bit               valid, ovf, dz;
        logic [WIDTH-1:0] res;
        int               lat, firstDone, doneCount;
        bit               busyOk, quietOk;

        refModel(op, a, b, valid, res, ovf, dz, lat);
        ac      = a;
        mbr     = b;
        ula_sel = op;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ac      = WIDTH'($urandom);
        mbr     = WIDTH'($urandom);
        ula_sel = SEL_W'($urandom);

        firstDone = -1;
        doneCount = 0;
        busyOk    = 1;
        quietOk   = 1;
        for (int cyc = 1; cyc <= lat + 4; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                doneCount++;
                if (firstDone < 0) firstDone = cyc;
            end
            if (cyc <= lat && !busy) busyOk = 0;
            if (cyc > lat && (busy || done)) quietOk = 0;
            if (cyc == reStartAfter) begin
                start   = 1'b1;
                ula_sel = SEL_W'(2);
                ac      = WIDTH'($urandom);
                mbr     = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
        end

        if (valid) begin
            mRes = res;
            mZ   = (res == '0);
            mN   = res[WIDTH-1];
            mDz  = dz;
            mV   = ovf;
        end

        checkOutput({tag, "_latency"}, firstDone, lat);
        checkOutput({tag, "_doneCount"}, doneCount, 1);
        checkOutput({tag, "_busyHeld"}, busyOk, 1);
        checkOutput({tag, "_quietAfter"}, quietOk, 1);
        checkState(tag);
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        bit               sawDone;
        logic [3:0]       op;
        int               mode, reStart, lat;

        rst     = 1'b1;
        start   = 1'b0;
        ula_re  = 1'b1;
        ac      = '0;
        mbr     = '0;
        ula_sel = '0;
        mRes    = '0;
        mZ      = 0;
        mN      = 0;
        mDz     = 0;
        mV      = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkState("reset");
        rst = 1'b0;

        applyStimulus("add_5_m7", 4'd2, 16'd5, 16'hFFF9, -1);
        ula_re = 1'b0;
        #1;
        checkOutput("bus_released", resultBus, 32'h0000FFFF);
        ula_re = 1'b1;
        #1;
        checkOutput("bus_driven", resultBus, 32'h0000FFFE);

        applyStimulus("sub_3_3", 4'd3, 16'd3, 16'd3, -1);
        applyStimulus("and", 4'd6, 16'h00F0, 16'h0F0F, -1);
        applyStimulus("or", 4'd7, 16'h00F0, 16'h0F0F, -1);
        applyStimulus("not", 4'd8, 16'h1234, 16'h0000, -1);
        applyStimulus("add_ovf", 4'd2, 16'h7FFF, 16'h0001, -1);
        applyStimulus("mul_m3_7", 4'd4, 16'hFFFD, 16'd7, 4);
        applyStimulus("invalid", 4'd12, 16'h1111, 16'h2222, 1);
        applyStimulus("div_m7_2", 4'd5, 16'hFFF9, 16'd2, -1);
        applyStimulus("div_min_m1", 4'd5, 16'h8000, 16'hFFFF, -1);
        applyStimulus("mul_min_m1", 4'd4, 16'h8000, 16'hFFFF, MUL_LAT);
        applyStimulus("div_9_0", 4'd5, 16'd9, 16'd0, -1);
        applyStimulus("add_1_1", 4'd2, 16'd1, 16'd1, -1);

        // Reset in the middle of a multiply must abort it without a done pulse.
        ac      = 16'hFFFD;
        mbr     = 16'd7;
        ula_sel = 4'd4;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        sawDone = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1;
            rst = (cyc == 5);
        end
        mRes = '0;
        mZ   = 0;
        mN   = 0;
        mDz  = 0;
        mV   = 0;
        checkOutput("abort_busy", busy, 0);
        checkState("abort");
        for (int cyc = 0; cyc < MUL_LAT + 3; cyc++) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1;
        end
        checkOutput("abort_noDone", sawDone, 0);
        applyStimulus("add_after_abort", 4'd2, 16'd20, 16'hFFF6, -1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 8))
                0:       op = 4'd2;
                1:       op = 4'd3;
                2:       op = 4'd4;
                3:       op = 4'd5;
                4:       op = 4'd6;
                5:       op = 4'd7;
                6:       op = 4'd8;
                7:       op = 4'($urandom_range(0, 1));
                default: op = 4'($urandom_range(9, 15));
            endcase
            lat  = (op == 4'd4 || op == 4'd5) ? MUL_LAT : 1;
            mode = $urandom_range(0, 3);
            if (mode == 1)                reStart = lat;
            else if (mode == 2 && lat > 1) reStart = $urandom_range(1, lat - 1);
            else                          reStart = -1;
            applyStimulus($sformatf("rnd%0d_op%0d", i, op), op, pickOperand(), pickOperand(), reStart);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
